// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the core LSU (C) and a debug port (D).
// Core has fixed priority; a starvation counter and a debug lock guarantee debug progress.
module dmem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                c_req,
    input  logic                c_we,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    input  logic [DATA_W/8-1:0] c_be,
    output logic                c_gnt,
    output logic                c_rvalid,
    output logic [DATA_W-1:0]   c_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic                d_lock,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        DLOCK = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] starve_cnt;
    logic       rd_pend;
    logic       rd_owner;   // 0 = core, 1 = debug
    logic       conflict;

    // Grant selection from current requests and registered arbitration state.
    always_comb begin
        c_gnt    = 1'b0;
        d_gnt    = 1'b0;
        conflict = 1'b0;
        case (state)
            ARB: begin
                conflict = c_req & d_req;
                if (conflict) begin
                    if (starve_cnt >= LIM) begin
                        d_gnt = 1'b1;
                    end else begin
                        c_gnt = 1'b1;
                    end
                end else begin
                    c_gnt = c_req;
                    d_gnt = d_req;
                end
            end
            DLOCK: begin
                d_gnt = d_req;
            end
            default: begin
                c_gnt = 1'b0;
                d_gnt = 1'b0;
            end
        endcase
    end

    // Memory port mux; idle cycles drive zeros.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
        end else if (c_gnt) begin
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
            mem_be    = c_be;
        end else begin
            mem_we    = 1'b0;
        end
    end

    assign mem_en = c_gnt | d_gnt;

    // Arbitration state, starvation counter and read-return tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB;
            starve_cnt <= 4'd0;
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            rd_pend  <= mem_en & ~mem_we;
            rd_owner <= d_gnt;
            case (state)
                ARB: begin
                    if (d_gnt) begin
                        starve_cnt <= 4'd0;
                        if (d_lock) begin
                            state <= DLOCK;
                        end
                    end else if (conflict && (starve_cnt < LIM)) begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                DLOCK: begin
                    starve_cnt <= 4'd0;
                    if (!d_lock) begin
                        state <= ARB;
                    end
                end
                default: begin
                    state      <= ARB;
                    starve_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Read data is steered only to the port that issued the read one cycle earlier.
    assign c_rvalid = rd_pend & ~rd_owner;
    assign d_rvalid = rd_pend & rd_owner;
    assign c_rdata  = c_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-enabled synchronous memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, c_gnt, c_rvalid;
    logic [9:0]  c_addr;
    logic [31:0] c_wdata, c_rdata;
    logic [3:0]  c_be;
    logic        d_req, d_we, d_lock, d_gnt, d_rvalid;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [31:0] mem [0:1023];

    int n_chk  = 0;
    int n_pass = 0;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_LIM(4)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory: synchronous byte-enabled write, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic set_c(input logic req, input logic we, input logic [9:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        c_req = req; c_we = we; c_addr = a; c_wdata = wd; c_be = be;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [9:0] a,
                         input logic [31:0] wd, input logic [3:0] be, input logic lk);
        d_req = req; d_we = we; d_addr = a; d_wdata = wd; d_be = be; d_lock = lk;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        set_c(1'b0, 1'b0, 10'd0, 32'd0, 4'h0);
        set_d(1'b0, 1'b0, 10'd0, 32'd0, 4'h0, 1'b0);
    endtask

    task automatic chk_gnt(input string tag, input logic ec, input logic ed);
        @(negedge clk);
        chk({tag, "_cgnt"}, {31'd0, c_gnt}, {31'd0, ec});
        chk({tag, "_dgnt"}, {31'd0, d_gnt}, {31'd0, ed});
    endtask

    bit [9:0] starve_pat;
    bit [4:0] post_rst_pat;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem_rdata = 32'd0;
        rst = 1'b1;
        idle();
        nxt(); nxt();
        @(negedge clk);
        chk("rst_cgnt", {31'd0, c_gnt}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_rvalid", {30'd0, c_rvalid, d_rvalid}, 32'd0);
        chk("rst_rdata", c_rdata | d_rdata, 32'd0);
        nxt();

        // Core-only write then read of addr 22.
        rst = 1'b0;
        set_c(1'b1, 1'b1, 10'd22, 32'h0000001E, 4'hF);
        chk_gnt("cw22", 1'b1, 1'b0);
        chk("cw22_mem", {mem_en, mem_we, 20'd0, mem_addr}, {1'b1, 1'b1, 20'd0, 10'd22});
        chk("cw22_wdata", mem_wdata, 32'h0000001E);
        nxt();
        set_c(1'b1, 1'b0, 10'd22, 32'd0, 4'hF);
        chk_gnt("cr22", 1'b1, 1'b0);
        chk("cw22_no_rvalid", {31'd0, c_rvalid}, 32'd0);
        nxt();
        idle();
        @(negedge clk);
        chk("cr22_rvalid", {30'd0, c_rvalid, d_rvalid}, 32'd2);
        chk("cr22_rdata", c_rdata, 32'h0000001E);
        chk("cr22_drdata", d_rdata, 32'd0);
        chk("idle_mem", {30'd0, mem_en, mem_we}, 32'd0);
        nxt();
        @(negedge clk);
        chk("cr22_one_shot", {31'd0, c_rvalid}, 32'd0);

        // d_lock alone in ARB does nothing; also preload addr 4.
        set_d(1'b0, 1'b0, 10'd0, 32'd0, 4'h0, 1'b1);
        set_c(1'b1, 1'b1, 10'd4, 32'hA5A50004, 4'hF);
        nxt();
        chk_gnt("lock_noreq", 1'b1, 1'b0);
        nxt();

        // Starvation: both held, expect C,C,C,C,D,C,C,C,C,D.
        starve_pat = 10'b10000_10000;
        set_c(1'b1, 1'b1, 10'd100, 32'h00000064, 4'hF);
        set_d(1'b1, 1'b0, 10'd4, 32'd0, 4'hF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk_gnt($sformatf("starve%0d", i), !starve_pat[i], starve_pat[i]);
            chk($sformatf("starve%0d_crv", i), {31'd0, c_rvalid}, 32'd0);
            if (i > 0 && starve_pat[i-1]) begin
                chk($sformatf("starve%0d_drv", i), {31'd0, d_rvalid}, 32'd1);
                chk($sformatf("starve%0d_drd", i), d_rdata, 32'hA5A50004);
                chk($sformatf("starve%0d_crd", i), c_rdata, 32'd0);
            end
            nxt();
        end
        idle();
        @(negedge clk);
        chk("starve_last_drd", {d_rvalid, d_rdata[30:0]}, {1'b1, 31'h25A50004});
        nxt();

        // Debug lock: writes 16..18, lock held, c_req high from the second cycle.
        set_d(1'b1, 1'b1, 10'd16, 32'hD0000010, 4'hF, 1'b1);
        chk_gnt("lock0", 1'b0, 1'b1);
        nxt();
        set_c(1'b1, 1'b0, 10'd16, 32'd0, 4'hF);
        for (int i = 1; i < 3; i++) begin
            set_d(1'b1, 1'b1, 10'(16 + i), 32'hD0000010 + 32'(i), 4'hF, 1'b1);
            chk_gnt($sformatf("lock%0d", i), 1'b0, 1'b1);
            nxt();
        end
        set_d(1'b0, 1'b0, 10'd0, 32'd0, 4'h0, 1'b1);
        chk_gnt("lock3_noreq", 1'b0, 1'b0);
        nxt();
        set_d(1'b1, 1'b1, 10'd19, 32'hD0000013, 4'hF, 1'b0);
        chk_gnt("lock_drop", 1'b0, 1'b1);
        nxt();
        set_d(1'b0, 1'b0, 10'd0, 32'd0, 4'h0, 1'b0);
        chk_gnt("after_lock", 1'b1, 1'b0);
        nxt();
        set_c(1'b1, 1'b0, 10'd17, 32'd0, 4'hF);
        @(negedge clk);
        chk("rd16", {c_rvalid, c_rdata[30:0]}, {1'b1, 31'h50000010});
        nxt();
        set_c(1'b1, 1'b0, 10'd18, 32'd0, 4'hF);
        @(negedge clk);
        chk("rd17", {c_rvalid, c_rdata[30:0]}, {1'b1, 31'h50000011});
        nxt();
        idle();
        @(negedge clk);
        chk("rd18", {c_rvalid, c_rdata[30:0]}, {1'b1, 31'h50000012});
        chk("rd18_full", c_rdata, 32'hD0000012);
        nxt();

        // Byte enables on addr 8.
        set_d(1'b1, 1'b1, 10'd8, 32'hFFFFFFFF, 4'hF, 1'b0);
        nxt();
        set_d(1'b0, 1'b0, 10'd0, 32'd0, 4'h0, 1'b0);
        set_c(1'b1, 1'b1, 10'd8, 32'h00000000, 4'h3);
        nxt();
        idle();
        set_d(1'b1, 1'b0, 10'd8, 32'd0, 4'hF, 1'b0);
        nxt();
        idle();
        @(negedge clk);
        chk("be_drv", {31'd0, d_rvalid}, 32'd1);
        chk("be_drdata", d_rdata, 32'hFFFF0000);
        nxt();

        // Interleaved reads: core addr 4 then debug addr 8.
        set_c(1'b1, 1'b0, 10'd4, 32'd0, 4'hF);
        chk_gnt("il_c", 1'b1, 1'b0);
        nxt();
        idle();
        set_d(1'b1, 1'b0, 10'd8, 32'd0, 4'hF, 1'b0);
        @(negedge clk);
        chk("il_n1_valid", {30'd0, c_rvalid, d_rvalid}, 32'd2);
        chk("il_n1_crd", c_rdata, 32'hA5A50004);
        chk("il_n1_drd", d_rdata, 32'd0);
        nxt();
        idle();
        @(negedge clk);
        chk("il_n2_valid", {30'd0, c_rvalid, d_rvalid}, 32'd1);
        chk("il_n2_drd", d_rdata, 32'hFFFF0000);
        chk("il_n2_crd", c_rdata, 32'd0);
        nxt();

        // Mid-run reset: build starve_cnt to 3 with core reads, then reset.
        set_c(1'b1, 1'b0, 10'd22, 32'd0, 4'hF);
        set_d(1'b1, 1'b0, 10'd4, 32'd0, 4'hF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_gnt($sformatf("pre_rst%0d", i), 1'b1, 1'b0);
            nxt();
        end
        rst = 1'b1;
        idle();
        @(negedge clk);
        chk("midrst_rvalid", {30'd0, c_rvalid, d_rvalid}, 32'd0);
        chk("midrst_rdata", c_rdata | d_rdata, 32'd0);
        chk("midrst_mem", {30'd0, mem_en, mem_we}, 32'd0);
        nxt();
        rst = 1'b0;
        post_rst_pat = 5'b10000;
        set_c(1'b1, 1'b1, 10'd200, 32'd1, 4'hF);
        set_d(1'b1, 1'b1, 10'd201, 32'd2, 4'hF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk_gnt($sformatf("post_rst%0d", i), !post_rst_pat[i], post_rst_pat[i]);
            nxt();
        end
        idle();
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
